// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART byte transmitter.
// UART_TX_PARITY_EN adds the PARITY state to the state encoding.
package uart_pkg;

    localparam int DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } tx_state_t;
`endif

    // Rounded clocks per bit cell.
    function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-cell timer: counts 0..CLKS_PER_BIT-1 and pulses o_cell_end on the last clock of a cell.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    output logic o_cell_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last     = (r_cnt == CNT_MAX);
    assign o_cell_end = w_last && !i_clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// 8-bit UART transmitter with one-cycle accept strobe toward the command translator.
// Define UART_TX_PARITY_EN to append an even-parity bit after the data bits.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 50_000_000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ_HZ, BAUD)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ascii_in,
    input  logic        cmd_ready,
    output logic        uart_ready,
    output logic        tx,
    output logic        busy,
    output logic [15:0] frames_sent
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    tx_state_t          r_state, w_state_nx;
    logic [7:0]         r_shift, w_shift_nx;
    logic [IDX_W-1:0]   r_bit_idx, w_bit_idx_nx;
    logic               r_tx, w_tx_nx;
    logic               r_uart_ready, w_uart_ready_nx;
    logic [15:0]        r_frames, w_frames_nx;
    logic               w_cell_end;
`ifdef UART_TX_PARITY_EN
    logic               r_parity, w_parity_nx;
`endif

    // Counter is held at zero while idle so the start cell is a full cell.
    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (r_state == IDLE),
        .o_cell_end (w_cell_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_bit_idx    <= '0;
            r_tx         <= 1'b1;
            r_uart_ready <= 1'b0;
            r_frames     <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity     <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nx;
            r_shift      <= w_shift_nx;
            r_bit_idx    <= w_bit_idx_nx;
            r_tx         <= w_tx_nx;
            r_uart_ready <= w_uart_ready_nx;
            r_frames     <= w_frames_nx;
`ifdef UART_TX_PARITY_EN
            r_parity     <= w_parity_nx;
`endif
        end
    end

    // tx_nx is the line level for the state being entered, so tx stays a pure register.
    always_comb begin
        w_state_nx      = r_state;
        w_shift_nx      = r_shift;
        w_bit_idx_nx    = r_bit_idx;
        w_tx_nx         = r_tx;
        w_uart_ready_nx = 1'b0;
        w_frames_nx     = r_frames;
`ifdef UART_TX_PARITY_EN
        w_parity_nx     = r_parity;
`endif
        case (r_state)
            IDLE: begin
                w_tx_nx = 1'b1;
                if (cmd_ready) begin
                    w_state_nx      = START;
                    w_shift_nx      = ascii_in;
                    w_bit_idx_nx    = '0;
                    w_tx_nx         = 1'b0;
                    w_uart_ready_nx = 1'b1;
`ifdef UART_TX_PARITY_EN
                    w_parity_nx     = ^ascii_in;
`endif
                end
            end
            START: begin
                if (w_cell_end) begin
                    w_state_nx = DATA;
                    w_tx_nx    = r_shift[0];
                end
            end
            DATA: begin
                if (w_cell_end) begin
                    if (r_bit_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nx = PARITY;
                        w_tx_nx    = r_parity;
`else
                        w_state_nx = STOP;
                        w_tx_nx    = 1'b1;
`endif
                    end else begin
                        w_shift_nx   = {1'b0, r_shift[7:1]};
                        w_bit_idx_nx = r_bit_idx + 1'b1;
                        w_tx_nx      = r_shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_cell_end) begin
                    w_state_nx = STOP;
                    w_tx_nx    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (w_cell_end) begin
                    w_state_nx  = IDLE;
                    w_tx_nx     = 1'b1;
                    w_frames_nx = r_frames + 16'd1;
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_tx_nx    = 1'b1;
            end
        endcase
    end

    assign tx          = r_tx;
    assign uart_ready  = r_uart_ready;
    assign busy        = (r_state != IDLE);
    assign frames_sent = r_frames;

endmodule
